serial_magnitude_comparator: RTL
================================

Name: serial_magnitude_comparator

Overview:
Bit-serial magnitude comparator for two unsigned WIDTH-bit operands. Operands arrive one bit pair per accepted cycle instead of as parallel vectors. Bit order is selectable: LSB-first or MSB-first. After WIDTH accepted bit pairs, the block registers a one-hot gt/eq/lt verdict and pulses done. It sits behind serial links and shift-register datapaths that have no parallel word available to the combinational comparators.

Parameters:
WIDTH, 8, operand width in bits; legal range >= 2.
MSB_FIRST, 0, bit order: 0 = LSB sent first, 1 = MSB sent first.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  begin a new comparison; sampled only in IDLE.
bit_valid  input  1  a_bit/b_bit carry a valid bit pair this cycle.
a_bit  input  1  current bit of operand a.
b_bit  input  1  current bit of operand b.
busy  output  1  high in SHIFT and DONE.
done  output  1  one-cycle pulse; result valid from this cycle.
gt  output  1  a > b.
eq  output  1  a == b.
lt  output  1  a < b.
bit_count  output  $clog2(WIDTH)+1  bit pairs accepted in the current comparison.

Behaviour:
- Reset (async assert, sync deassert relative to clk edge):
  - state = IDLE.
  - busy = 0, done = 0, gt = 0, eq = 0, lt = 0, bit_count = 0.
  - Internal running flags: run_gt = 0, run_lt = 0.
- State machine: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE:
  - start = 1 -> SHIFT next cycle.
  - On that transition: bit_count = 0, run_gt = 0, run_lt = 0, gt/eq/lt cleared to 0.
  - bit_valid in IDLE is ignored, including in the same cycle as start.
- SHIFT:
  - Each cycle with bit_valid = 1 accepts one bit pair and increments bit_count.
  - Cycles with bit_valid = 0 stall; no state change.
  - start is ignored.
- Accumulation, LSB-first (MSB_FIRST = 0):
  - If a_bit != b_bit: run_gt = a_bit, run_lt = b_bit.
  - Otherwise the flags hold.
  - A later (more significant) differing bit overrides earlier ones.
- Accumulation, MSB-first (MSB_FIRST = 1):
  - The first differing bit sets run_gt/run_lt.
  - Once either flag is set, both lock until the next start.
- Completion:
  - The cycle that accepts the WIDTH-th bit -> DONE next cycle.
  - On entry to DONE: gt = run_gt, lt = run_lt, eq = ~(run_gt | run_lt), done = 1.
  - Exactly one of gt/eq/lt is high.
- DONE:
  - Lasts exactly 1 cycle, then -> IDLE with done = 0.
  - gt/eq/lt hold until the next accepted start.
  - bit_valid and start are ignored in DONE.
- Latency: done rises 1 cycle after the last accepted bit. Minimum start-to-done is WIDTH+1 cycles.
- Back-to-back comparisons: start may be asserted in the first IDLE cycle after DONE.
- bit_count saturates at WIDTH; it never wraps while in SHIFT.
- Reset mid-comparison: immediate return to the reset values above. The partial result is discarded and no done pulse is produced.
- X on a_bit/b_bit when bit_valid = 0 must not affect state.

Test Plan:
- WIDTH=8, MSB_FIRST=0: start, then send a=0xA5, b=0x5A LSB-first on 8 consecutive valid cycles -> done pulses 1 cycle after the 8th bit (9 cycles after start accepted); gt=1, eq=0, lt=0; bit_count=8.
- WIDTH=8, MSB_FIRST=1: send a=0x3C, b=0x3D -> lt=1. Then send a=0x80, b=0x7F -> gt=1 (lock on first bit; later differing bits ignored).
- Equal operands a=b=0xFF, then a=b=0x00 -> eq=1, gt=lt=0 both times; results held stable for 5 idle cycles after done.
- Stalls: same operands as the first scenario, with bit_valid deasserted for 3 random cycles mid-stream -> same verdict; done delayed by exactly 3 cycles; bit_count never exceeds 8.
- Protocol abuse: bit_valid=1 with start in the same IDLE cycle, and a second start asserted in SHIFT -> first bit not consumed; the second start has no effect; the verdict reflects only the 8 bits sent after start.
- Async reset: drop rst_n after 4 bits of a comparison, between clock edges -> all outputs 0 immediately; a fresh comparison a=0x01, b=0x02 afterwards yields lt=1.

Source files
------------

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator for two unsigned WIDTH-bit operands.
// One bit pair is accepted per valid cycle in SHIFT. After WIDTH pairs the
// block registers a one-hot gt/eq/lt verdict and pulses done for one cycle.
//
// Handshake: there is no ready. A bit pair is consumed on every rising edge
// where the block is in SHIFT and bit_valid = 1. bit_valid, a_bit and b_bit
// are ignored in IDLE and DONE. start is sampled only in IDLE.
//
// The state register is exported on dbg_state so checkers can bind to it.

module serial_magnitude_comparator #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       bit_valid,
  input  logic                       a_bit,
  input  logic                       b_bit,
  output logic                       busy,
  output logic                       done,
  output logic                       gt,
  output logic                       eq,
  output logic                       lt,
  output logic [$clog2(WIDTH):0]     bit_count,
  output logic [1:0]                 dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  // Count value held while the last bit pair is being accepted, and the
  // saturation ceiling of the counter.
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   bit_count_q, bit_count_d;
  logic            run_gt_q, run_gt_d;
  logic            run_lt_q, run_lt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            gt_q, gt_d;
  logic            eq_q, eq_d;
  logic            lt_q, lt_d;

  // Qualifiers shared by the next-state and datapath logic. Everything that
  // looks at a_bit/b_bit is gated by accept, so undriven bits during stall
  // cycles never reach state.
  logic start_cmp;
  logic accept;
  logic last_bit;
  logic flags_locked;

  assign start_cmp    = (state_q == S_IDLE) && start;
  assign accept       = (state_q == S_SHIFT) && bit_valid;
  assign last_bit     = accept && (bit_count_q == LAST_IDX);
  // In MSB-first order the first differing pair decides everything, so the
  // flags freeze once either is set. LSB-first never freezes: a later pair
  // is more significant and must override.
  assign flags_locked = MSB_FIRST && (run_gt_q || run_lt_q);

  // Next-state logic for the IDLE -> SHIFT -> DONE -> IDLE sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (last_bit) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bit counter and running comparison flags.
  always_comb begin
    bit_count_d = bit_count_q;
    run_gt_d    = run_gt_q;
    run_lt_d    = run_lt_q;
    if (start_cmp) begin
      bit_count_d = '0;
      run_gt_d    = 1'b0;
      run_lt_d    = 1'b0;
    end else if (accept) begin
      if (bit_count_q != FULL_CNT) begin
        bit_count_d = bit_count_q + CW'(1);
      end
      if ((a_bit != b_bit) && !flags_locked) begin
        run_gt_d = a_bit;
        run_lt_d = b_bit;
      end
    end
  end

  // Registered outputs, computed from the state being entered so that busy
  // and done line up with the state register.
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    gt_d   = gt_q;
    eq_d   = eq_q;
    lt_d   = lt_q;
    if (start_cmp) begin
      gt_d = 1'b0;
      eq_d = 1'b0;
      lt_d = 1'b0;
    end else if (last_bit) begin
      // The final pair is folded in through the _d flags so the verdict
      // includes it.
      gt_d = run_gt_d;
      lt_d = run_lt_d;
      eq_d = ~(run_gt_d | run_lt_d);
    end
  end

  // State register and datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_count_q <= '0;
      run_gt_q    <= 1'b0;
      run_lt_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_count_q <= bit_count_d;
      run_gt_q    <= run_gt_d;
      run_lt_q    <= run_lt_d;
    end
  end

  // Output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      gt_q   <= 1'b0;
      eq_q   <= 1'b0;
      lt_q   <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      gt_q   <= gt_d;
      eq_q   <= eq_d;
      lt_q   <= lt_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign gt        = gt_q;
  assign eq        = eq_q;
  assign lt        = lt_q;
  assign bit_count = bit_count_q;
  assign dbg_state = state_q;

endmodule
